// File: rtl/ifid_imm_stage.sv
// ifid_imm_stage: IF/ID FIFO stage that splits the head instruction into MIPS fields and drives the sign-extension bit.
// Optional build macro IMM_ZERO_EXT_EN clears imm_sign for andi/ori/xori so the extender zero-extends them.
module ifid_imm_stage #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [5:0]      funct,
    output logic [15:0]     imm16,
    output logic            imm_sign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    assign in_ready  = count < FULL;
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= in_instr;
                pc_mem[wr_ptr]    <= in_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign opcode    = out_instr[31:26];
    assign rs        = out_instr[25:21];
    assign rt        = out_instr[20:16];
    assign rd        = out_instr[15:11];
    assign funct     = out_instr[5:0];
    assign imm16     = out_instr[15:0];

`ifdef IMM_ZERO_EXT_EN
    assign imm_sign = (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E) ? 1'b0 : out_instr[15];
`else
    assign imm_sign = out_instr[15];
`endif
endmodule

// File: tb/tb_ifid_imm_stage.sv
// tb_ifid_imm_stage: directed and random stimulus against a queue reference model of the IF/ID stage.
module tb_ifid_imm_stage;
    localparam int PC_W  = 32;
    localparam int DEPTH = 2;

    logic            clk = 0;
    logic            rst_n = 0;
    logic            flush = 0;
    logic            in_valid = 0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic            imm_sign;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;
    entry_t q[$];

    ifid_imm_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
        .imm_sign(imm_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic exp_sign(input logic [31:0] i);
        int op;
        op = int'(i / 32'd67108864);
`ifdef IMM_ZERO_EXT_EN
        if (op >= 12 && op <= 14) return 1'b0;
`endif
        return i[15];
    endfunction

    // Reference model: a bounded queue updated on every clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (flush) q.delete();
        else begin
            bit w, p;
            w = in_valid && (q.size() < DEPTH);
            p = out_ready && (q.size() != 0);
            if (p) void'(q.pop_front());
            if (w) q.push_back('{in_instr, in_pc});
        end
    end

    // Monitor: compare handshake and head payload against the model each cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_instr", 64'(out_instr), 64'(q[0].instr));
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                chk("opcode", 64'(opcode), 64'(q[0].instr / 32'h0400_0000));
                chk("rs", 64'(rs), 64'((q[0].instr / 32'h0020_0000) % 32));
                chk("rt", 64'(rt), 64'((q[0].instr / 32'h0001_0000) % 32));
                chk("rd", 64'(rd), 64'((q[0].instr / 32'h0000_0800) % 32));
                chk("funct", 64'(funct), 64'(q[0].instr % 64));
                chk("imm16", 64'(imm16), 64'(q[0].instr % 65536));
                chk("imm_sign", 64'(imm_sign), 64'(exp_sign(q[0].instr)));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_imm_sign", 64'(imm_sign), 64'd0);
        @(posedge clk);
        #1 rst_n = 1;
        cyc();

        // addi $8,$0,-4
        in_valid = 1; in_instr = 32'h2008FFFC; in_pc = 32'h0040_0000; out_ready = 1;
        cyc();
        in_valid = 0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_opcode", 64'(opcode), 64'h08);
        chk("t1_rt", 64'(rt), 64'd8);
        chk("t1_imm16", 64'(imm16), 64'hFFFC);
        chk("t1_sign", 64'(imm_sign), 64'd1);
        chk("t1_pc", 64'(out_pc), 64'h0040_0000);
        cyc(2);

        // fill, block third word, then drain
        out_ready = 0;
        in_valid = 1; in_instr = 32'h1111_0001; in_pc = 32'h100; cyc();
        in_instr = 32'h2222_0002; in_pc = 32'h104; cyc();
        chk("t2_full", 64'(in_ready), 64'd0);
        in_instr = 32'h3333_0003; in_pc = 32'h108; cyc(2);
        chk("t2_held", 64'(out_instr), 64'h1111_0001);
        out_ready = 1; cyc();
        chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
        chk("t3_head2", 64'(out_instr), 64'h2222_0002);
        cyc();
        in_valid = 0;
        chk("t2_head3", 64'(out_instr), 64'h3333_0003);
        cyc(2);

        // half-full push+pop keeps one entry
        out_ready = 0; in_valid = 1; in_instr = 32'h4444_0004; cyc();
        out_ready = 1; in_instr = 32'h5555_0005; cyc();
        in_valid = 0; out_ready = 0;
        chk("t3_cnt1_valid", 64'(out_valid), 64'd1);
        chk("t3_cnt1_ready", 64'(in_ready), 64'd1);
        chk("t3_cnt1_head", 64'(out_instr), 64'h5555_0005);
        out_ready = 1; cyc(2);

        // flush with two entries and a concurrent push
        out_ready = 0; in_valid = 1; in_instr = 32'h6666_0006; cyc();
        in_instr = 32'h7777_0007; cyc();
        flush = 1; in_instr = 32'h8888_0008; cyc();
        flush = 0; in_valid = 0;
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_ready", 64'(in_ready), 64'd1);
        cyc(2);

        // imm_sign for ori and addi
        in_valid = 1; in_instr = 32'h3508FFFF; cyc();
        in_valid = 0;
`ifdef IMM_ZERO_EXT_EN
        chk("t5_ori_sign", 64'(imm_sign), 64'd0);
`else
        chk("t5_ori_sign", 64'(imm_sign), 64'd1);
`endif
        out_ready = 1; cyc();
        out_ready = 0; in_valid = 1; in_instr = 32'h2108FFFF; cyc();
        in_valid = 0;
        chk("t5_addi_sign", 64'(imm_sign), 64'd1);
        out_ready = 1; cyc(2);

        // asynchronous reset mid-stream
        out_ready = 0; in_valid = 1; in_instr = 32'h9999_0009; cyc();
        in_instr = 32'hAAAA_000A; cyc();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1 rst_n = 1;
        in_valid = 1; in_instr = 32'hBBBB_000B; in_pc = 32'h200; cyc();
        in_valid = 0;
        chk("t6_repush", 64'(out_instr), 64'hBBBB_000B);
        out_ready = 1; cyc();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            r = $urandom();
            op = ($urandom_range(0, 3) == 0) ? 6'(12 + $urandom_range(0, 2)) : 6'($urandom_range(0, 63));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = {op, r[25:0]};
            in_pc     = $urandom();
            cyc();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
